imm_ctrl: RTL and testbench

IMM_CTRL -- requirements
Module: imm_ctrl

---
 rtl/imm_ctrl_pkg.sv | 22 ++
 rtl/imm_extend_unit.sv | 13 +
 rtl/imm_ctrl.sv | 126 ++++++++++++
 tb/tb_imm_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ctrl_pkg.sv
// Shared types and widths for the immediate-extension controller.
// Mode and state encodings live here so the top and the extender agree on them.
package imm_ctrl_pkg;

    localparam int IMM_W  = 12;
    localparam int DATA_W = 16;
    localparam int HI_W   = 4;

    typedef enum logic [1:0] {
        MODE_ZX12 = 2'b00,
        MODE_SX12 = 2'b01,
        MODE_LD16 = 2'b10,
        MODE_ILL  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT_HI = 2'b01,
        OUT     = 2'b10
    } state_e;

endpackage

// File: rtl/imm_extend_unit.sv
// Combinational 12->16 extender; sign_ext selects sign- or zero-extension.
// Latency 0, no flow control of its own.
module imm_extend_unit
    import imm_ctrl_pkg::*;
(
    input  logic [IMM_W-1:0]  imm,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] ext
);

    assign ext = {{(DATA_W-IMM_W){sign_ext & imm[IMM_W-1]}}, imm};

endmodule

// File: rtl/imm_ctrl.sv
// Immediate controller: zero/sign-extends a 12-bit immediate or assembles a two-part 16-bit load.
// Latency 1 from request (or upper nibble) to out_valid; out_data held until out_ready.
// Mode 01 sign-extension exists only when IMM_SIGN_EXT_EN is defined; otherwise mode 01 is illegal.
module imm_ctrl
    import imm_ctrl_pkg::*;
#(
    parameter int unsigned HI_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_mode,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic              hi_valid,
    output logic              hi_ready,
    input  logic [HI_W-1:0]   hi_nibble,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err
);

    localparam logic [7:0] TIMEOUT_C = 8'(HI_TIMEOUT);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IMM_W-1:0]    lo_q, lo_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [7:0]          cnt_inc;
    logic                sign_sel;
    logic [DATA_W-1:0]   ext_dat;

`ifdef IMM_SIGN_EXT_EN
    assign sign_sel = (req_mode == MODE_SX12);
`else
    assign sign_sel = 1'b0;
`endif

    imm_extend_unit u_ext (
        .imm      (imm_in),
        .sign_ext (sign_sel),
        .ext      (ext_dat)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        cnt_inc = cnt_q + 8'd1;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    case (mode_e'(req_mode))
                        MODE_ZX12: begin
                            data_d  = ext_dat;
                            state_d = OUT;
                        end
                        MODE_SX12: begin
`ifdef IMM_SIGN_EXT_EN
                            data_d  = ext_dat;
                            state_d = OUT;
`else
                            err_d   = 1'b1;
`endif
                        end
                        MODE_LD16: begin
                            lo_d    = imm_in;
                            cnt_d   = 8'd0;
                            state_d = WAIT_HI;
                        end
                        MODE_ILL: begin
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_HI: begin
                // An upper nibble arriving in the timeout cycle still wins.
                if (hi_valid) begin
                    data_d  = {hi_nibble, lo_q};
                    state_d = OUT;
                end else if (cnt_inc == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    lo_d    = '0;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            lo_q    <= '0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign hi_ready  = (state_q == WAIT_HI);
    assign out_valid = (state_q == OUT);
    assign out_data  = data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imm_ctrl.sv
// Directed self-checking bench for imm_ctrl; expectations are hand-computed constants.
module tb_imm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_mode = 2'b00;
    logic [11:0] imm_in = 12'h000;
    logic        hi_valid = 1'b0;
    logic        hi_ready;
    logic [3:0]  hi_nibble = 4'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        err;

    int tests = 0;
    int fails = 0;

    imm_ctrl #(.HI_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .imm_in    (imm_in),
        .hi_valid  (hi_valid),
        .hi_ready  (hi_ready),
        .hi_nibble (hi_nibble),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance one clock; sampling and driving both happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        tests++;
        if ({req_ready, hi_ready, out_valid, err, out_data} !== {4'b1000, 16'h0000}) begin
            fails++;
            $display("FAIL reset_state: rdy/hi/ov/err/data=%b_%h expected 1000_0000",
                     {req_ready, hi_ready, out_valid, err}, out_data);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_zx12();
        out_ready = 1'b1;
        req_valid = 1'b1; req_mode = 2'b00; imm_in = 12'hFFF;
        tick();
        req_valid = 1'b0;
        tests++;
        if ({out_valid, req_ready, out_data} !== {2'b10, 16'h0FFF}) begin
            fails++;
            $display("FAIL zx12_result: ov/rdy/data=%b_%h expected 10_0fff", {out_valid, req_ready}, out_data);
        end
        tick();
        tests++;
        if ({out_valid, req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL zx12_return_idle: ov/rdy=%b expected 01", {out_valid, req_ready});
        end
    endtask

    task automatic test_sx12();
        out_ready = 1'b1;
        req_valid = 1'b1; req_mode = 2'b01; imm_in = 12'h800;
        tick();
        req_valid = 1'b0;
`ifdef IMM_SIGN_EXT_EN
        tests++;
        if ({out_valid, err, out_data} !== {2'b10, 16'hF800}) begin
            fails++;
            $display("FAIL sx12_result: ov/err/data=%b_%h expected 10_f800", {out_valid, err}, out_data);
        end
        tick();
`else
        tests++;
        if ({err, out_valid, req_ready} !== 3'b101) begin
            fails++;
            $display("FAIL sx12_disabled_err: err/ov/rdy=%b expected 101", {err, out_valid, req_ready});
        end
        tick();
        tests++;
        if ({err, out_valid} !== 2'b00) begin
            fails++;
            $display("FAIL sx12_disabled_pulse: err/ov=%b expected 00", {err, out_valid});
        end
`endif
    endtask

    task automatic test_ld16_hold();
        out_ready = 1'b0;
        req_valid = 1'b1; req_mode = 2'b10; imm_in = 12'h234;
        tick();
        req_valid = 1'b0; imm_in = 12'h000;
        tests++;
        if ({hi_ready, req_ready, out_valid} !== 3'b100) begin
            fails++;
            $display("FAIL ld16_wait_hi: hi/rdy/ov=%b expected 100", {hi_ready, req_ready, out_valid});
        end
        tick();
        tick();
        hi_valid = 1'b1; hi_nibble = 4'hA;
        tick();
        hi_valid = 1'b0; hi_nibble = 4'h0;
        tests++;
        if ({out_valid, out_data} !== {1'b1, 16'hA234}) begin
            fails++;
            $display("FAIL ld16_result: ov/data=%b_%h expected 1_a234", out_valid, out_data);
        end
        // A request offered while OUT is held must be ignored.
        req_valid = 1'b1; req_mode = 2'b00; imm_in = 12'h555;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({out_valid, req_ready, out_data} !== {2'b10, 16'hA234}) begin
                fails++;
                $display("FAIL ld16_hold_%0d: ov/rdy/data=%b_%h expected 10_a234",
                         i, {out_valid, req_ready}, out_data);
            end
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++;
        if ({out_valid, req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL ld16_release: ov/rdy=%b expected 01", {out_valid, req_ready});
        end
    endtask

    task automatic test_timeout();
        out_ready = 1'b1;
        req_valid = 1'b1; req_mode = 2'b10; imm_in = 12'h111;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tests++;
            if ({hi_ready, err} !== 2'b10) begin
                fails++;
                $display("FAIL timeout_wait_%0d: hi/err=%b expected 10", i, {hi_ready, err});
            end
            tick();
        end
        tests++;
        if ({err, req_ready, hi_ready, out_valid} !== 4'b1100) begin
            fails++;
            $display("FAIL timeout_err: err/rdy/hi/ov=%b expected 1100", {err, req_ready, hi_ready, out_valid});
        end
        tick();
        tests++;
        if ({err, out_valid} !== 2'b00) begin
            fails++;
            $display("FAIL timeout_pulse: err/ov=%b expected 00", {err, out_valid});
        end
    endtask

    task automatic test_timeout_race();
        out_ready = 1'b1;
        req_valid = 1'b1; req_mode = 2'b10; imm_in = 12'h111;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        hi_valid = 1'b1; hi_nibble = 4'h5;
        tick();
        hi_valid = 1'b0;
        tests++;
        if ({out_valid, err, out_data} !== {2'b10, 16'h5111}) begin
            fails++;
            $display("FAIL timeout_race: ov/err/data=%b_%h expected 10_5111", {out_valid, err}, out_data);
        end
        tick();
        tests++;
        if ({err, req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL timeout_race_idle: err/rdy=%b expected 01", {err, req_ready});
        end
    endtask

    task automatic test_illegal();
        req_valid = 1'b1; req_mode = 2'b11; imm_in = 12'h777;
        tick();
        req_valid = 1'b0;
        tests++;
        if ({err, out_valid, req_ready} !== 3'b101) begin
            fails++;
            $display("FAIL illegal_err: err/ov/rdy=%b expected 101", {err, out_valid, req_ready});
        end
        tick();
        tests++;
        if ({err, out_valid} !== 2'b00) begin
            fails++;
            $display("FAIL illegal_pulse: err/ov=%b expected 00", {err, out_valid});
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_mode = 2'b10; imm_in = 12'hABC;
        tick();
        req_valid = 1'b0;
        tick();
        tests++;
        if (hi_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_pre: hi_ready=%b expected 1", hi_ready);
        end
        rst = 1'b1;
        #2;
        tests++;
        if ({req_ready, hi_ready, out_valid, err, out_data} !== {4'b1000, 16'h0000}) begin
            fails++;
            $display("FAIL reset_mid_async: rdy/hi/ov/err/data=%b_%h expected 1000_0000",
                     {req_ready, hi_ready, out_valid, err}, out_data);
        end
        tick();
        rst = 1'b0;
        req_valid = 1'b1; req_mode = 2'b00; imm_in = 12'h001;
        tick();
        req_valid = 1'b0;
        tests++;
        if ({out_valid, err, out_data} !== {2'b10, 16'h0001}) begin
            fails++;
            $display("FAIL reset_mid_after: ov/err/data=%b_%h expected 10_0001", {out_valid, err}, out_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        req_valid = 1'b1; req_mode = 2'b00; imm_in = 12'h010;
        tick();
        imm_in = 12'h020;
        tests++;
        if ({out_valid, req_ready, out_data} !== {2'b10, 16'h0010}) begin
            fails++;
            $display("FAIL b2b_first: ov/rdy/data=%b_%h expected 10_0010", {out_valid, req_ready}, out_data);
        end
        tick();
        tests++;
        if ({out_valid, req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL b2b_gap: ov/rdy=%b expected 01", {out_valid, req_ready});
        end
        tick();
        req_valid = 1'b0;
        tests++;
        if ({out_valid, out_data} !== {1'b1, 16'h0020}) begin
            fails++;
            $display("FAIL b2b_second: ov/data=%b_%h expected 1_0020", out_valid, out_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_zx12();
        test_sx12();
        test_ld16_hold();
        test_timeout();
        test_timeout_race();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
